// File: rtl/onchip_mem_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port 1-cycle on-chip RAM.
// Optional macro ONCHIP_BURST_RDREG_EN adds a register stage on the read return path.
module onchip_mem_burst_adapter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 4,
  parameter int MAX_BURST = 8,
  parameter int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic [BE_W-1:0]   s_byteenable,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic              burst_err,
  output logic [ADDR_W-1:0] m_address,
  output logic [BE_W-1:0]   m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  remaining;
  logic [BURST_W-1:0]  cmd_len;
  logic                oversize;
  logic                rd_vld_q;

  // Zero means a single word; anything above MAX_BURST is clipped and flagged.
  assign oversize = s_burstcount > BURST_W'(MAX_BURST);
  assign cmd_len  = (s_burstcount == '0) ? BURST_W'(1) :
                    oversize             ? BURST_W'(MAX_BURST) : s_burstcount;

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      s_waitrequest <= 1'b1;
      burst_err     <= 1'b0;
      addr_q        <= '0;
      remaining     <= '0;
      rd_vld_q      <= 1'b0;
      m_address     <= '0;
      m_byteenable  <= '0;
      m_chipselect  <= 1'b0;
      m_write       <= 1'b0;
      m_writedata   <= '0;
      m_clken       <= 1'b0;
    end else begin
      m_clken      <= 1'b1;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      // A read issued to the RAM last cycle has its data on m_readdata this cycle.
      rd_vld_q     <= m_chipselect & ~m_write;
      case (state)
        IDLE: begin
          s_waitrequest <= 1'b0;
          if (!s_waitrequest && s_write) begin
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_address    <= s_address;
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            addr_q       <= s_address + ADDR_W'(1);
            remaining    <= cmd_len - BURST_W'(1);
            burst_err    <= burst_err | oversize;
            if (cmd_len != BURST_W'(1)) state <= WR;
          end else if (!s_waitrequest && s_read) begin
            m_chipselect <= 1'b1;
            m_address    <= s_address;
            m_byteenable <= '1;
            addr_q       <= s_address + ADDR_W'(1);
            remaining    <= cmd_len - BURST_W'(1);
            burst_err    <= burst_err | oversize;
            if (cmd_len != BURST_W'(1)) begin
              state         <= RD;
              s_waitrequest <= 1'b1;
            end
          end
        end
        WR: begin
          if (s_write) begin
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_address    <= addr_q;
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            addr_q       <= addr_q + ADDR_W'(1);
            remaining    <= remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) state <= IDLE;
          end
        end
        RD: begin
          m_chipselect <= 1'b1;
          m_address    <= addr_q;
          m_byteenable <= '1;
          addr_q       <= addr_q + ADDR_W'(1);
          remaining    <= remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) begin
            state         <= IDLE;
            s_waitrequest <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ONCHIP_BURST_RDREG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= rd_vld_q;
      s_readdata      <= m_readdata;
    end
  end
`else
  assign s_readdatavalid = rd_vld_q;
  assign s_readdata      = m_readdata;
`endif

endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// Self-checking bench: RAM model, command-level memory/timing model, per-cycle compare.
module tb_onchip_mem_burst_adapter;
  localparam int MAX_BURST = 8;
`ifdef ONCHIP_BURST_RDREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] s_address = '0;
  logic [3:0]  s_burstcount = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [3:0]  s_byteenable = '0;
  logic        s_waitrequest, s_readdatavalid, burst_err;
  logic [31:0] s_readdata;
  logic [14:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken;
  logic [31:0] m_writedata, m_readdata;

  onchip_mem_burst_adapter dut (
    .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .burst_err(burst_err), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
    .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [14:0] a);
    return 32'hC0DE0000 | {17'b0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // RAM model: registered read, byte-enabled write.
  logic [31:0] ram [0:32767];
  bit          ram_wr [0:32767];
  logic [31:0] ram_q = '0;
  function automatic logic [31:0] ram_rd(input logic [14:0] a);
    return ram_wr[a] ? ram[a] : init_val(a);
  endfunction
  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write) begin
        ram[m_address]    <= merge(ram_rd(m_address), m_writedata, m_byteenable);
        ram_wr[m_address] <= 1'b1;
      end else begin
        ram_q <= ram_rd(m_address);
      end
    end
  end
  assign m_readdata = ram_q;

  // Reference memory updated at slave acceptance.
  logic [31:0] ref_mem [0:32767];
  bit          ref_wr [0:32767];
  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct { int cyc; bit wr; logic [14:0] addr; logic [31:0] data; logic [3:0] be; } mtx_t;
  typedef struct { int cyc; logic [31:0] data; } rtx_t;
  mtx_t mq[$];
  rtx_t rq[$];
  int rel_cyc = -10, rd_acc = -100, rd_len = 0, err_cyc = -1;

  logic [31:0] obs_rdata[$];
  int          obs_rcyc[$];
  logic [14:0] obs_waddr[$];

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clip(input logic [3:0] bc);
    if (bc == 0) return 1;
    if (bc > MAX_BURST) return MAX_BURST;
    return int'(bc);
  endfunction

  always @(negedge clk) begin : compare
    mtx_t m;
    rtx_t r;
    if (m_chipselect && m_write) obs_waddr.push_back(m_address);
    if (s_readdatavalid) begin
      obs_rdata.push_back(s_readdata);
      obs_rcyc.push_back(cyc);
    end
    if (!reset_n) begin
      check("rst_rdvalid", s_readdatavalid, 0);
      check("rst_cs", m_chipselect, 0);
      check("rst_wait", s_waitrequest, 1);
      check("rst_err", burst_err, 0);
      check("rst_clken", m_clken, 0);
    end else begin
      check("waitrequest", s_waitrequest,
            (cyc == rel_cyc) || (cyc > rd_acc && cyc < rd_acc + rd_len));
      check("clken", m_clken, cyc != rel_cyc);
      check("burst_err", burst_err, err_cyc >= 0 && cyc >= err_cyc);
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        m = mq.pop_front();
        check("m_cs", m_chipselect, 1);
        check("m_write", m_write, m.wr);
        check("m_addr", m_address, m.addr);
        check("m_be", m_byteenable, m.be);
        if (m.wr) check("m_wdata", m_writedata, m.data);
      end else begin
        check("m_idle_cs", m_chipselect, 0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check("rdvalid", s_readdatavalid, 1);
        check("rdata", s_readdata, r.data);
      end else begin
        check("rdvalid_idle", s_readdatavalid, 0);
      end
    end
  end

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    s_read = 1'b0;
    s_write = 1'b0;
    mq.delete();
    rq.delete();
    rd_acc = -100;
    rd_len = 0;
    err_cyc = -1;
    #1 check("rst_rdvalid_now", s_readdatavalid, 0);
    repeat (ncyc) @(posedge clk);
    #1 reset_n = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_accept(output bit ok);
    int g = 0;
    while (s_waitrequest && g < 40) begin @(negedge clk); g++; end
    check("accept_timeout", s_waitrequest, 0);
    ok = !s_waitrequest;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (s_waitrequest && g < 40) begin @(negedge clk); g++; end
    check("wait_idle_timeout", s_waitrequest, 0);
  endtask

  task automatic issue_read(input logic [14:0] a, input logic [3:0] bc, output int t);
    bit ok;
    int len;
    logic [14:0] ad;
    mtx_t m;
    rtx_t r;
    s_address = a; s_burstcount = bc; s_read = 1'b1;
    wait_accept(ok);
    t = cyc;
    if (ok) begin
      len = clip(bc);
      if (bc > MAX_BURST && err_cyc < 0) err_cyc = t + 1;
      for (int k = 0; k < len; k++) begin
        ad = a + 15'(k);
        m.cyc = t + 1 + k; m.wr = 1'b0; m.addr = ad; m.data = '0; m.be = 4'hF;
        mq.push_back(m);
        r.cyc = t + LAT + k; r.data = ref_rd(ad);
        rq.push_back(r);
      end
      rd_acc = t; rd_len = len;
      @(posedge clk);
    end
    #1 s_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_beat(input logic [14:0] a, input logic [3:0] bc, input logic [31:0] d,
                            input logic [3:0] be, output int t);
    bit ok;
    mtx_t m;
    s_address = a; s_burstcount = bc; s_writedata = d; s_byteenable = be; s_write = 1'b1;
    wait_accept(ok);
    t = cyc;
    if (ok) begin
      m.cyc = t + 1; m.wr = 1'b1; m.addr = a; m.data = d; m.be = be;
      mq.push_back(m);
      ref_mem[a] = merge(ref_rd(a), d, be);
      ref_wr[a] = 1'b1;
      @(posedge clk);
    end
    #1 s_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [14:0] a, input logic [3:0] bc, input logic [31:0] base,
                             input bit rnd, input int gap_max);
    int t;
    for (int k = 0; k < clip(bc); k++) begin
      if (k > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      write_beat(a + 15'(k), bc, rnd ? $urandom : base + k, rnd ? 4'($urandom_range(0, 15)) : 4'hF, t);
      if (k == 0 && bc > MAX_BURST && err_cyc < 0) err_cyc = t + 1;
    end
  endtask

  task automatic drain();
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic clear_logs();
    obs_rdata.delete(); obs_rcyc.delete(); obs_waddr.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    logic [14:0] a;
    do_reset(3);

    // Single word write/readback with exact latency
    write_beat(15'h0010, 4'd1, 32'hDEADBEEF, 4'hF, t);
    clear_logs();
    issue_read(15'h0010, 4'd1, t);
    wait_idle(); drain();
    check("t1_count", obs_rdata.size(), 1);
    if (obs_rdata.size() > 0) begin
      check("t1_data", obs_rdata[0], 32'hDEADBEEF);
      check("t1_latency", 64'(obs_rcyc[0] - t), 64'(LAT));
    end

    // Byte-lane merge
    write_beat(15'h0020, 4'd1, 32'h11223344, 4'hF, t);
    write_beat(15'h0020, 4'd1, 32'hAAAAAAAA, 4'h2, t);
    clear_logs();
    issue_read(15'h0020, 4'd1, t);
    wait_idle(); drain();
    if (obs_rdata.size() > 0) check("t2_data", obs_rdata[0], 32'h1122AA44);
    else check("t2_count", obs_rdata.size(), 1);

    // Address wrap on a write and read burst
    clear_logs();
    write_burst(15'h7FFE, 4'd4, 32'd1, 1'b0, 0);
    drain();
    check("t3_wcount", obs_waddr.size(), 4);
    if (obs_waddr.size() == 4) begin
      check("t3_waddr0", obs_waddr[0], 15'h7FFE);
      check("t3_waddr1", obs_waddr[1], 15'h7FFF);
      check("t3_waddr2", obs_waddr[2], 15'h0000);
      check("t3_waddr3", obs_waddr[3], 15'h0001);
    end
    clear_logs();
    issue_read(15'h7FFE, 4'd4, t);
    wait_idle(); drain();
    check("t3_rcount", obs_rdata.size(), 4);
    foreach (obs_rdata[i]) check("t3_rdata", obs_rdata[i], 32'(i + 1));

    // Back-to-back maximum read bursts
    clear_logs();
    issue_read(15'h0000, 4'd8, t);
    wait_idle();
    issue_read(15'h0008, 4'd8, t);
    wait_idle(); drain();
    check("t4_count", obs_rdata.size(), 16);
    if (obs_rcyc.size() == 16) check("t4_contiguous", 64'(obs_rcyc[15] - obs_rcyc[0]), 15);

    // Zero and oversize burstcount
    clear_logs();
    write_burst(15'h0100, 4'd0, 32'h5555_0000, 1'b0, 0);
    issue_read(15'h0100, 4'd0, t);
    wait_idle(); drain();
    check("t5_zero_wr", obs_waddr.size(), 1);
    check("t5_zero_rd", obs_rdata.size(), 1);
    clear_logs();
    issue_read(15'h0040, 4'd12, t);
    wait_idle(); drain();
    check("t5_clip_count", obs_rdata.size(), 8);
    check("t5_err_set", burst_err, 1);
    do_reset(2);
    check("t5_err_cleared", burst_err, 0);

    // Reset in the middle of a read burst
    issue_read(15'h0200, 4'd8, t);
    @(posedge clk);
    do_reset(2);
    clear_logs();
    repeat (15) @(negedge clk);
    check("t6_no_stray_rd", obs_rdata.size(), 0);
    check("t6_no_stray_wr", obs_waddr.size(), 0);

    // Randomized mix of commands
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 15'(15'h7FF8 + $urandom_range(0, 7))
                                      : 15'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1) begin
        write_burst(a, 4'($urandom_range(0, 15)), 32'h0, 1'b1, 2);
      end else begin
        issue_read(a, 4'($urandom_range(0, 15)), t);
        wait_idle();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("end_mq_empty", mq.size(), 0);
    check("end_rq_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
